fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 108 ++++++++++
 tb/tb_fp_mul_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP multiplier between two
// requesters; holds operands steady while the multiplier is stalling.
module fp_mul_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic        busy0,
  output logic        busy1,
  output logic        mrun,
  output logic [31:0] mx,
  output logic [31:0] my,
  input  logic        mstall,
  input  logic [31:0] mz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        owner_q;
  logic        last_q;
  logic        mrun_q;
  logic        done0_q;
  logic        done1_q;
  logic [31:0] mx_q;
  logic [31:0] my_q;
  logic [31:0] r0_q;
  logic [31:0] r1_q;
  logic        grant_d;

  // On contention, pick whoever was not granted last.
  always_comb begin
    grant_d = req1 & (~req0 | ~last_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      mrun_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      mx_q    <= '0;
      my_q    <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            owner_q <= grant_d;
            last_q  <= grant_d;
            mx_q    <= grant_d ? x1 : x0;
            my_q    <= grant_d ? y1 : y0;
            mrun_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!mstall) begin
            if (owner_q) begin
              r1_q    <= mz;
              done1_q <= 1'b1;
            end else begin
              r0_q    <= mz;
              done0_q <= 1'b1;
            end
            mrun_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          mrun_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign r0    = r0_q;
  assign r1    = r1_q;
  assign mrun  = mrun_q;
  assign mx    = mx_q;
  assign my    = my_q;
  assign busy0 = rst & req0 & ~done0_q;
  assign busy1 = rst & req1 & ~done1_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: stalling multiplier model, transaction-level
// reference, directed scenarios and randomized traffic.
module tb_fp_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] x0 = '0;
  logic [31:0] y0 = '0;
  logic [31:0] x1 = '0;
  logic [31:0] y1 = '0;
  logic        done0, done1, busy0, busy1, mrun, mstall;
  logic [31:0] r0, r1, mx, my, mz;

  int n_err = 0;
  int n_chk = 0;

  fp_mul_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .done0(done0), .done1(done1),
    .r0(r0), .r1(r1),
    .busy0(busy0), .busy1(busy1),
    .mrun(mrun), .mx(mx), .my(my),
    .mstall(mstall), .mz(mz)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic [23:0] ma, mb;
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    m  = ma * mb;
    e  = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
    return {s, e[7:0], m[45:23]};
  endfunction

  function automatic logic [31:0] rndfp();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(100, 150));
    if ($urandom_range(0, 15) == 0) v[30:0] = '0;
    return v;
  endfunction

  // Multiplier: stalls for 25 cycles after mrun rises.
  logic [5:0] mcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) mcnt <= '0;
    else if (mrun) mcnt <= mcnt + 6'd1;
    else mcnt <= '0;
  end
  assign mstall = mrun && (mcnt < 6'd25);
  assign mz = fmul(mx, my);

  // Reference: phase 0 idle, 1..26 running, 27 done pulse.
  int          m_phase;
  logic        m_owner, m_last;
  logic [31:0] m_opx, m_opy, m_r0, m_r1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_owner = 0; m_last = 1;
      m_opx = 0; m_opy = 0; m_r0 = 0; m_r1 = 0;
    end else if (m_phase == 0) begin
      if (req0 || req1) begin
        m_owner = (req0 && req1) ? !m_last : req1;
        m_last  = m_owner;
        m_opx   = m_owner ? x1 : x0;
        m_opy   = m_owner ? y1 : y0;
        m_phase = 1;
      end
    end else if (m_phase == 26) begin
      if (m_owner) m_r1 = fmul(m_opx, m_opy);
      else m_r0 = fmul(m_opx, m_opy);
      m_phase = 27;
    end else if (m_phase == 27) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic em, ed0, ed1;
    if (!rst) begin
      chk("rst_mrun", 32'(mrun), 0);
      chk("rst_done", {30'd0, done1, done0}, 0);
      chk("rst_busy", {30'd0, busy1, busy0}, 0);
      chk("rst_mx", mx, 0);
      chk("rst_my", my, 0);
      chk("rst_r0", r0, 0);
      chk("rst_r1", r1, 0);
    end else begin
      em  = (m_phase >= 1 && m_phase <= 26);
      ed0 = (m_phase == 27) && !m_owner;
      ed1 = (m_phase == 27) && m_owner;
      chk("mrun", 32'(mrun), 32'(em));
      chk("done0", 32'(done0), 32'(ed0));
      chk("done1", 32'(done1), 32'(ed1));
      chk("r0", r0, m_r0);
      chk("r1", r1, m_r1);
      chk("busy0", 32'(busy0), 32'(req0 && !ed0));
      chk("busy1", 32'(busy1), 32'(req1 && !ed1));
      if (em) begin
        chk("mx", mx, m_opx);
        chk("my", my, m_opy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int who, output int lat);
    bit seen;
    seen = 0;
    lat = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (who == 0 ? done0 : done1) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, ndone, lowcnt;
    bit seenhigh, pd0, pd1;
    logic [31:0] ord [$];

    repeat (3) tick();
    rst = 1;
    tick();

    // Single request: 2.0 * 3.0
    x0 = 32'h40000000; y0 = 32'h40400000; req0 = 1;
    wait_done(0, lat);
    #1 req0 = 0;
    chk("single_lat", lat, 27);
    chk("single_r0", r0, 32'h40C00000);
    chk("single_r1", r1, 0);
    repeat (3) tick();

    // Contention from reset, held through four operations
    rst = 0;
    x0 = 32'h40000000; y0 = 32'h40400000;
    x1 = 32'h40400000; y1 = 32'h40400000;
    req0 = 1; req1 = 1;
    tick();
    rst = 1;
    ndone = 0; lowcnt = 0; seenhigh = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 300 && ndone < 4; i++) begin
      @(negedge clk);
      if (done0) begin ord.push_back(0); ndone++; chk("d0_width", 32'(pd0), 0); end
      if (done1) begin ord.push_back(1); ndone++; chk("d1_width", 32'(pd1), 0); end
      pd0 = done0; pd1 = done1;
      if (mrun) begin
        if (seenhigh && lowcnt > 0) chk("mrun_gap", lowcnt, 2);
        seenhigh = 1; lowcnt = 0;
      end else lowcnt++;
    end
    #1 req0 = 0; req1 = 0;
    chk("fair_count", ord.size(), 4);
    if (ord.size() == 4) begin
      chk("order0", ord[0], 0);
      chk("order1", ord[1], 1);
      chk("order2", ord[2], 0);
      chk("order3", ord[3], 1);
    end
    chk("fair_r0", r0, 32'h40C00000);
    chk("fair_r1", r1, 32'h41100000);
    repeat (3) tick();

    // Zero operand
    x1 = 32'h00000000; y1 = 32'h3F800000; req1 = 1;
    wait_done(1, lat);
    #1 req1 = 0;
    chk("zero_lat", lat, 27);
    chk("zero_r1", r1, 0);
    repeat (2) tick();

    // Drop req mid-RUN: 2.0 * 2.0
    x0 = 32'h40000000; y0 = 32'h40000000; req0 = 1;
    repeat (8) tick();
    req0 = 0;
    wait_done(0, lat);
    chk("drop_r0", r0, 32'h40800000);
    repeat (2) tick();

    // Reset mid-RUN, then request completes with full latency
    x0 = 32'h3FC00000; y0 = 32'h40000000; req0 = 1;
    repeat (10) tick();
    rst = 0;
    #1 chk("abort_mrun", 32'(mrun), 0);
    tick();
    rst = 1;
    wait_done(0, lat);
    #1 req0 = 0;
    chk("abort_lat", lat, 27);
    chk("abort_r0", r0, 32'h40400000);
    repeat (2) tick();

    // Operand stability: 1.5 * 4.0 with toggling inputs
    x0 = 32'h3FC00000; y0 = 32'h40800000; req0 = 1;
    @(posedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done0) break;
      #1 x0 = $urandom; y0 = $urandom;
    end
    #1 req0 = 0;
    chk("stable_r0", r0, 32'h40C00000);
    repeat (2) tick();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) req0 = !req0;
      if ($urandom_range(0, 7) == 0) req1 = !req1;
      x0 = rndfp(); y0 = rndfp();
      x1 = rndfp(); y1 = rndfp();
    end
    req0 = 0; req1 = 0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
